pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Tuse/Tnew stall/flush scheduler with MDU busy tracking and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md_use,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_op,
  output logic             stall,
  output logic             flush_E,
  output logic             md_busy,
  output logic [3:0]       md_count,
  output logic             md_overlap,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [3:0]       md_count_q, md_count_d;
  logic             md_overlap_q, md_overlap_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md;
  always_comb begin
    stall_rs = (D_rs != 5'd0) && ((E_wa == D_rs && E_tnew > D_tuse_rs) || (M_wa == D_rs && M_tnew > D_tuse_rs));
    stall_rt = (D_rt != 5'd0) && ((E_wa == D_rt && E_tnew > D_tuse_rt) || (M_wa == D_rt && M_tnew > D_tuse_rt));
    md_busy  = (state_q == BUSY) || E_md_start;
    stall_md = D_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    flush_E  = stall;
    state_d      = state_q;
    md_count_d   = md_count_q;
    md_overlap_d = md_overlap_q || (state_q == BUSY && E_md_start);
    if (state_q == IDLE && E_md_start) begin
      md_count_d = E_md_op ? 4'(DIV_CYC) : 4'(MULT_CYC);
      state_d    = BUSY;
    end else if (state_q == BUSY) begin
      md_count_d = md_count_q - 4'd1;
      state_d    = (md_count_q == 4'd1) ? IDLE : BUSY;
    end
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      md_count_q   <= '0;
      md_overlap_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_count_q   <= md_count_d;
      md_overlap_q <= md_overlap_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end
  assign md_count   = md_count_q;
  assign md_overlap = md_overlap_q;
  assign stall_cnt  = stall_cnt_q;
endmodule
